// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares the 8 KB main RAM between the 6502 and a DMA loader.
// CPU slots always win the RAM port. Loader writes queue in a small FIFO and
// drain in cycles the CPU leaves free. A starvation guard holds the CPU for
// one slot (cpu_ready low) when the loader has been denied too long.
// Optional feature macro: RAM_ARB_READ_EN adds the loader read path
// (dma_rd_* ports, RD_ISSUE/RD_WAIT states).
module ram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk14,
  input  logic                          rst,
  input  logic                          cpu_clken,
  input  logic                          cpu_cs,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [7:0]                    cpu_wdata,
  output logic                          cpu_ready,
  input  logic                          dma_wr_valid,
  output logic                          dma_wr_ready,
  input  logic [ADDR_W-1:0]             dma_wr_addr,
  input  logic [7:0]                    dma_wr_data,
`ifdef RAM_ARB_READ_EN
  input  logic                          dma_rd_req,
  input  logic [ADDR_W-1:0]             dma_rd_addr,
  output logic                          dma_rd_ack,
  output logic [7:0]                    dma_rd_data,
`endif
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [7:0]                    ram_din,
  input  logic [7:0]                    ram_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
  localparam logic [7:0]       LIMIT    = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

  state_t            state;
  logic              cpu_ready_reg, cpu_ready_next;
  logic [7:0]        starve_reg, starve_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] last_addr_reg;
  logic [7:0]        last_din_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic              cpu_own, fifo_empty, push, pop, rd_issue, dma_access, dma_pending;

  // Ownership and request qualification
  assign cpu_own      = cpu_clken & cpu_ready_reg & cpu_cs;
  assign fifo_empty   = (level_reg == '0);
  assign dma_wr_ready = (level_reg != FULL_LVL);
  assign push         = dma_wr_valid & dma_wr_ready;
  assign pop          = ~cpu_own & ~fifo_empty & (state == IDLE);
  assign rd_issue     = ~cpu_own & (state == RD_ISSUE);
  assign dma_access   = pop | rd_issue;
  // The loader is actually waiting for the port (a read in RD_WAIT is not)
  assign dma_pending  = (~fifo_empty & (state == IDLE)) | (state == RD_ISSUE);
  assign busy         = ~fifo_empty | (state != IDLE);
  assign fifo_level   = level_reg;
  assign cpu_ready    = cpu_ready_reg;

  // RAM port mux: CPU first, then FIFO drain, then read issue, else hold
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = last_addr_reg;
    ram_din  = last_din_reg;
    if (cpu_own) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end else if (pop) begin
      ram_we   = 1'b1;
      ram_addr = fifo_addr[rd_ptr_reg];
      ram_din  = fifo_data[rd_ptr_reg];
    end else if (rd_issue) begin
      ram_addr = rd_addr;
    end
  end

  // Remember the last driven address/data so an unowned port holds still
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      last_addr_reg <= '0;
      last_din_reg  <= '0;
    end else begin
      last_addr_reg <= ram_addr;
      last_din_reg  <= ram_din;
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked separately
  always_ff @(posedge clk14) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= dma_wr_addr;
      fifo_data[wr_ptr_reg] <= dma_wr_data;
    end
  end

  // Next FIFO occupancy: simultaneous push and pop cancel out
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + ONE_LVL;
      2'b01:   level_next = level_reg - ONE_LVL;
      default: level_next = level_reg;
    endcase
  end

  // FIFO pointers (power-of-two depth, so they wrap naturally) and level
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // Starvation guard: count denied cycles, steal one CPU slot at the limit
  always_comb begin
    starve_next    = starve_reg;
    cpu_ready_next = 1'b1;
    if (dma_access) begin
      starve_next = '0;
    end else if (dma_pending && cpu_own) begin
      if ((starve_reg + 8'd1) >= LIMIT) begin
        starve_next    = '0;
        cpu_ready_next = 1'b0;
      end else begin
        starve_next = starve_reg + 8'd1;
      end
    end
  end

  // Starvation counter and registered cpu_ready
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      starve_reg    <= '0;
      cpu_ready_reg <= 1'b1;
    end else begin
      starve_reg    <= starve_next;
      cpu_ready_reg <= cpu_ready_next;
    end
  end

`ifdef RAM_ARB_READ_EN
  state_t     state_reg, state_next;
  logic       rd_capture;
  logic       rd_ack_reg;
  logic [7:0] rd_data_reg;

  assign state       = state_reg;
  assign rd_addr     = dma_rd_addr;
  assign dma_rd_ack  = rd_ack_reg;
  assign dma_rd_data = rd_data_reg;

  // Read FSM state register
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Read FSM next state; a read starts only once queued writes have drained,
  // and the request is ignored in the ack cycle so a late drop is harmless
  always_comb begin
    state_next = state_reg;
    rd_capture = 1'b0;
    case (state_reg)
      IDLE:     if (dma_rd_req && fifo_empty && !rd_ack_reg) state_next = RD_ISSUE;
      RD_ISSUE: if (!cpu_own) state_next = RD_WAIT;
      RD_WAIT: begin
        rd_capture = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Capture synchronous RAM output and pulse the ack
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      rd_ack_reg  <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rd_ack_reg <= rd_capture;
      if (rd_capture) rd_data_reg <= ram_dout;
    end
  end
`else
  logic [7:0] unused_ram_dout;

  assign state           = IDLE;
  assign rd_addr         = '0;
  assign unused_ram_dout = ram_dout;
`endif

endmodule
